seq_array_divider: RTL and testbench

Sequential restoring divider: the inverse of the team's combinational 4x4 array multiplier. It takes an 8-bit dividend and a 4-bit divisor and produces an 8-bit quotient and a 4-bit remainder, one quotient bit per clock. A start/busy/done handshake lets it sit behind a controller or testbench. Products of the 4x4 multiplier fed back in as the dividend, with either multiplier operand as the divisor, must return the other operand exactly.

---
 rtl/divider_pkg.sv | 13 +
 rtl/fulladd.sv | 13 +
 rtl/sub_ripple.sv | 28 ++
 rtl/seq_array_divider.sv | 111 +++++++++++
 tb/tb_seq_array_divider.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared widths and FSM encoding for the sequential restoring divider.
package divider_pkg;

    localparam int N_DEF = 8;
    localparam int M_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fulladd.sv
// One-bit full adder cell shared with the array multiplier.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_ripple.sv
// Ripple-borrow subtractor a - b built as a + ~b + 1 from full adders.
// nob is the final carry: high when a >= b.
module sub_ripple #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         nob
);

    logic [W:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fulladd u_fa (
            .a   (a[i]),
            .b   (~b[i]),
            .cin (c[i]),
            .s   (diff[i]),
            .cout(c[i+1])
        );
    end

    assign nob = c[W];

endmodule

// File: rtl/seq_array_divider.sv
// Sequential restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with a one-cycle divide-by-zero path.
//
// state   | meaning
// IDLE    | waiting for start; operands latched on the accepting edge
// CALC    | shifting in one quotient bit per edge, N edges total
// DONE    | done pulse, result registers hold the new result
module seq_array_divider
    import divider_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  dq;
    logic [M-1:0]  dv;
    logic [M:0]    pr;
    logic [CW-1:0] cnt;

    logic [M:0]    t;
    logic [M:0]    diff;
    logic          q_bit;
    logic [M:0]    pr_next;
    logic          pr_msb_unused;

    // pr[M] is always 0 after a restoring step; only the low bits feed t
    assign pr_msb_unused = pr[M];

    assign t       = {pr[M-1:0], dq[N-1]};
    assign pr_next = q_bit ? diff : t;

    sub_ripple #(.W(M + 1)) u_sub (
        .a   (t),
        .b   ({1'b0, dv}),
        .diff(diff),
        .nob (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            dq        <= '0;
            dv        <= '0;
            pr        <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            dq    <= dividend;
                            dv    <= divisor;
                            pr    <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= ST_CALC;
                        end else begin
                            quotient  <= '1;
                            remainder <= dividend[M-1:0];
                            div_zero  <= 1'b1;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_CALC: begin
                    pr  <= pr_next;
                    dq  <= {dq[N-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient  <= {dq[N-2:0], q_bit};
                        remainder <= pr_next[M-1:0];
                        div_zero  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_divider.sv
// Self-checking bench for seq_array_divider: directed table, exhaustive
// sweep against a / and % model, and hand-written handshake corner cases.
module tb_seq_array_divider;

    localparam int N = 8;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_array_divider #(.N(N), .M(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    typedef struct {
        int dd;
        int ds;
        int q;
        int r;
        int z;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first cycle in which a new start can be accepted.
    task automatic run_div(input int dd, input int ds, input int eq,
                           input int er, input int ez);
        int k;
        int bcnt;
        dividend = dd[N-1:0];
        divisor  = ds[M-1:0];
        start    = 1'b1;
        @(posedge clk);
        bcnt = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
            if (busy) bcnt++;
        end
        chk($sformatf("latency %0d/%0d", dd, ds), k, (ez != 0) ? 1 : N + 1);
        chk($sformatf("busy_cycles %0d/%0d", dd, ds), bcnt, (ez != 0) ? 0 : N);
        chk($sformatf("busy_with_done %0d/%0d", dd, ds), int'(busy), 0);
        chk($sformatf("quotient %0d/%0d", dd, ds), int'(quotient), eq);
        chk($sformatf("remainder %0d/%0d", dd, ds), int'(remainder), er);
        chk($sformatf("div_zero %0d/%0d", dd, ds), int'(div_zero), ez);
        @(negedge clk);
        chk($sformatf("done_width %0d/%0d", dd, ds), int'(done), 0);
    endtask

    vec_t vecs[12];

    initial begin
        int ndone;
        int dk;

        vecs[0]  = '{255, 15, 17, 0, 0};
        vecs[1]  = '{200, 7, 28, 4, 0};
        vecs[2]  = '{5, 12, 0, 5, 0};
        vecs[3]  = '{100, 0, 255, 4, 1};
        vecs[4]  = '{9, 2, 4, 1, 0};
        vecs[5]  = '{0, 1, 0, 0, 0};
        vecs[6]  = '{255, 1, 255, 0, 0};
        vecs[7]  = '{128, 3, 42, 2, 0};
        vecs[8]  = '{7, 7, 1, 0, 0};
        vecs[9]  = '{1, 15, 0, 1, 0};
        vecs[10] = '{225, 15, 15, 0, 0};
        vecs[11] = '{0, 0, 255, 0, 1};

        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd3;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", int'(dut.state), 0);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_div_zero", int'(div_zero), 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // Back-to-back runs: each starts at the earliest legal edge
        for (int i = 0; i < 12; i++)
            run_div(vecs[i].dd, vecs[i].ds, vecs[i].q, vecs[i].r, vecs[i].z);

        for (int dd = 0; dd < 256; dd++)
            for (int ds = 1; ds < 16; ds++)
                run_div(dd, ds, dd / ds, dd % ds, 0);

        // Extra starts during CALC must be ignored
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        ndone = 0;
        dk    = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 5);
            if (start) begin
                dividend = 8'd50;
                divisor  = 4'd3;
            end
            if (done) begin
                ndone++;
                dk = k;
            end
        end
        start = 1'b0;
        chk("ignored_start_done_count", ndone, 1);
        chk("ignored_start_done_cycle", dk, N + 1);
        chk("ignored_start_quotient", int'(quotient), 28);
        chk("ignored_start_remainder", int'(remainder), 4);

        // Reset in cycle 4 of CALC aborts the job
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_state", int'(dut.state), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_div_zero", int'(div_zero), 0);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_div(9, 2, 4, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
